cp_wr_dt_pack: RTL

Write-side data converter for the AES coprocessor input path. Accepts 32-bit word writes from the host-facing input buffer (9-bit word address), packs four consecutive words of the same 128-bit line into an accumulator, and issues one registered 128-bit write per line to the coprocessor input buffer (7-bit line address). Lane mapping is word `addr[1:0]` to bits `[32*addr[1:0] +: 32]`, the same mapping the read-side converter uses, so a line written here reads back identically.

---
 rtl/cp_wr_dt_pack.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cp_wr_dt_pack.sv
// Write-side 32->128 packer for the AES coprocessor input buffer.
// Gathers four lanes of a line and issues one registered line write.
module cp_wr_dt_pack (
    input  logic         iClk,
    input  logic         iRsn,
    input  logic         iWrEn_InBuf,
    input  logic [8:0]   iWrAddr_InBuf,
    input  logic [31:0]  iWrDt_InBuf,
    input  logic         iFlush,
    input  logic         iErrClr,
    output logic         oWrEn_CpInBuf,
    output logic [6:0]   oWrAddr_CpInBuf,
    output logic [127:0] oWrDt_CpInBuf,
    output logic         oBusy,
    output logic         oErrDrop,
    output logic [15:0]  oLineCnt
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FILL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [127:0]   r_acc;
    logic [3:0]     r_msk;
    logic [6:0]     r_cur;
    logic           r_wr_en;
    logic [6:0]     r_wr_addr;
    logic [127:0]   r_wr_dt;
    logic           r_err;
    logic [15:0]    r_line_cnt;

    logic [1:0]     w_lane;
    logic [6:0]     w_line;
    logic [3:0]     w_sel;
    logic [127:0]   w_lane_dt;
    logic [127:0]   w_lane_keep;
    logic           w_new_line;
    logic [127:0]   w_base_acc;
    logic [3:0]     w_base_msk;
    logic [127:0]   w_m_acc;
    logic [3:0]     w_m_msk;
    logic           w_issue;
    logic           w_drop;
    logic [6:0]     w_iss_addr;
    logic [127:0]   w_iss_dt;
    logic [127:0]   w_acc_nxt;
    logic [3:0]     w_msk_nxt;
    logic [6:0]     w_cur_nxt;

    assign w_lane      = iWrAddr_InBuf[1:0];
    assign w_line      = iWrAddr_InBuf[8:2];
    assign w_sel       = 4'b0001 << w_lane;
    assign w_lane_dt   = {96'b0, iWrDt_InBuf} << {w_lane, 5'b0};
    assign w_lane_keep = ~({96'b0, 32'hFFFF_FFFF} << {w_lane, 5'b0});
    assign w_new_line  = iWrEn_InBuf && (r_state == ST_FILL)
                         && (w_line != r_cur);

    // A word for another line (or into EMPTY) merges onto a cleared line
    assign w_base_acc = (r_state == ST_FILL && !w_new_line) ? r_acc : '0;
    assign w_base_msk = (r_state == ST_FILL && !w_new_line) ? r_msk : '0;
    assign w_m_acc    = (w_base_acc & w_lane_keep) | w_lane_dt;
    assign w_m_msk    = w_base_msk | w_sel;

    always_comb begin
        w_issue    = 1'b0;
        w_drop     = 1'b0;
        w_iss_addr = r_cur;
        w_iss_dt   = r_acc;
        w_acc_nxt  = r_acc;
        w_msk_nxt  = r_msk;
        w_cur_nxt  = r_cur;
        if (w_new_line) begin
            if (iFlush) w_issue = 1'b1;
            else        w_drop  = 1'b1;
            w_acc_nxt = w_lane_dt;
            w_msk_nxt = w_sel;
            w_cur_nxt = w_line;
        end else if (iWrEn_InBuf) begin
            w_acc_nxt = w_m_acc;
            w_cur_nxt = w_line;
            if (w_m_msk == 4'hF || iFlush) begin
                w_issue    = 1'b1;
                w_iss_addr = w_line;
                w_iss_dt   = w_m_acc;
                w_msk_nxt  = 4'h0;
            end else begin
                w_msk_nxt  = w_m_msk;
            end
        end else if (iFlush && r_state == ST_FILL) begin
            w_issue   = 1'b1;
            w_msk_nxt = 4'h0;
        end
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (1'b1)
            (w_msk_nxt != 4'h0): w_state_nxt = ST_FILL;
            (w_msk_nxt == 4'h0): w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        oBusy = (r_state == ST_FILL);
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_acc      <= '0;
            r_msk      <= '0;
            r_cur      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_dt    <= '0;
            r_err      <= 1'b0;
            r_line_cnt <= '0;
        end else begin
            r_acc   <= w_acc_nxt;
            r_msk   <= w_msk_nxt;
            r_cur   <= w_cur_nxt;
            r_wr_en <= w_issue;
            if (w_issue) begin
                r_wr_addr  <= w_iss_addr;
                r_wr_dt    <= w_iss_dt;
                r_line_cnt <= r_line_cnt + 16'd1;
            end
            if (w_drop)       r_err <= 1'b1;
            else if (iErrClr) r_err <= 1'b0;
        end
    end

    assign oWrEn_CpInBuf   = r_wr_en;
    assign oWrAddr_CpInBuf = r_wr_addr;
    assign oWrDt_CpInBuf   = r_wr_dt;
    assign oErrDrop        = r_err;
    assign oLineCnt        = r_line_cnt;

endmodule
